// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-beat memory port between an instruction-fetch requester
//   and a load/store data requester. A request is granted combinationally in
//   IDLE. The access runs in BUSY until the memory answers, and the winner
//   receives a one-cycle response in RESP. Misaligned or badly-masked accesses
//   skip the memory and return an error response.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request (word reads only)
//   if_gnt/if_rvalid/if_rdata/if_err   fetch grant and response
//   d_req/d_we/d_addr/d_wdata      data request
//   d_byte_mask/d_load_sign        access size (0001/0011/1111) and load extension
//   d_gnt/d_rvalid/d_rdata/d_err   data grant and response
//   mem_en/mem_we/mem_addr/mem_wdata   memory command (valid only while BUSY)
//   mem_rdata/mem_ready            memory read data and completion
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_mask,
  input  logic        d_load_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_e;

  state_e      state_q, state_d;
  src_e        last_q, last_d;    // requester granted most recently
  src_e        owner_q, owner_d;  // requester of the access in flight
  logic        store_q, store_d;
  logic [3:0]  mask_q, mask_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        pick_data;
  logic        if_misalign;
  logic        d_misalign;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  // On a conflict the data side wins unless it was the last one served.
  assign pick_data   = d_req && (!if_req || (last_q == SRC_FETCH));
  assign if_misalign = |if_addr[1:0];
  assign d_misalign  = (d_byte_mask == 4'b0001) ? 1'b0 :
                       (d_byte_mask == 4'b0011) ? d_addr[0] :
                       (d_byte_mask == 4'b1111) ? |d_addr[1:0] : 1'b1;

  // Load data: move the addressed byte/half down to lane 0, then extend.
  assign load_shifted = mem_rdata >> {off_q, 3'b000};
  always_comb begin
    load_ext = load_shifted;
    case (mask_q)
      4'b0001: load_ext = {{24{sign_q & load_shifted[7]}},  load_shifted[7:0]};
      4'b0011: load_ext = {{16{sign_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    store_d     = store_q;
    mask_d      = mask_q;
    sign_d      = sign_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          rdata_d = '0;
          if (pick_data) begin
            d_gnt       = 1'b1;
            owner_d     = SRC_DATA;
            last_d      = SRC_DATA;
            store_d     = d_we;
            mask_d      = d_byte_mask;
            sign_d      = d_load_sign;
            off_d       = d_addr[1:0];
            mem_addr_d  = {d_addr[31:2], 2'b00};
            mem_we_d    = d_we ? (d_byte_mask << d_addr[1:0]) : 4'b0000;
            mem_wdata_d = d_wdata << {d_addr[1:0], 3'b000};
            err_d       = d_misalign;
          end else begin
            if_gnt      = 1'b1;
            owner_d     = SRC_FETCH;
            last_d      = SRC_FETCH;
            store_d     = 1'b0;
            mask_d      = 4'b1111;
            sign_d      = 1'b0;
            off_d       = 2'b00;
            mem_addr_d  = {if_addr[31:2], 2'b00};
            mem_we_d    = 4'b0000;
            mem_wdata_d = '0;
            err_d       = if_misalign;
          end
          // Errors bypass the memory entirely.
          state_d = err_d ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          if (owner_q == SRC_FETCH) rdata_d = mem_rdata;
          else if (store_q)         rdata_d = '0;
          else                      rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= SRC_FETCH;
      owner_q     <= SRC_FETCH;
      store_q     <= 1'b0;
      mask_q      <= 4'b0000;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      mask_q      <= mask_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Memory command is only presented while the access is in flight.
  assign mem_en    = (state_q == S_BUSY);
  assign mem_addr  = mem_en ? mem_addr_q  : '0;
  assign mem_we    = mem_en ? mem_we_q    : 4'b0000;
  assign mem_wdata = mem_en ? mem_wdata_q : '0;

  // Responses exist only during the single RESP cycle, routed to the owner.
  assign if_rvalid = (state_q == S_RESP) && (owner_q == SRC_FETCH);
  assign d_rvalid  = (state_q == S_RESP) && (owner_q == SRC_DATA);
  assign if_err    = if_rvalid && err_q;
  assign d_err     = d_rvalid  && err_q;
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid  ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change just after the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_load_sign;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_byte_mask;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_ready;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_mask(d_byte_mask), .d_load_sign(d_load_sign), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; caller then drives and waits #1.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_byte_mask = 4'b0000; d_load_sign = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic data_load(input logic [31:0] addr, input logic [3:0] mask,
                           input logic sign, input logic [31:0] rd,
                           input logic [31:0] exp, input string tag);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_byte_mask = mask; d_load_sign = sign; #1;
    check({tag, "_gnt"}, d_gnt, 1);
    tick();
    d_req = 1'b0; mem_rdata = rd; mem_ready = 1'b1; #1;
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_we"}, mem_we, 0);
    tick();
    mem_ready = 1'b0; #1;
    check({tag, "_rvalid"}, d_rvalid, 1);
    check({tag, "_rdata"}, d_rdata, exp);
    check({tag, "_err"}, d_err, 0);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rvalid", {if_rvalid, d_rvalid, if_err, d_err}, 0);

    // Fetch 0x100, memory ready on the third BUSY cycle.
    tick();
    if_req = 1'b1; if_addr = 32'h100; #1;
    check("f_if_gnt", if_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    tick();
    if_req = 1'b0; #1;
    check("f_mem_en", mem_en, 1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_we", mem_we, 0);
    check("f_gnt_busy", if_gnt, 0);
    tick(); #1;
    check("f_wait_en", mem_en, 1);
    check("f_wait_rvalid", if_rvalid, 0);
    tick();
    mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1; #1;
    tick();
    mem_ready = 1'b0; #1;
    check("f_rvalid", if_rvalid, 1);
    check("f_rdata", if_rdata, 32'hDEADBEEF);
    check("f_err", if_err, 0);
    check("f_d_rvalid", d_rvalid, 0);
    check("f_en_resp", mem_en, 0);
    tick(); #1;
    check("f_rvalid_drop", if_rvalid, 0);
    check("f_rdata_drop", if_rdata, 0);

    // Byte loads from 0x203: signed, then unsigned. Also halfword at 0x102.
    data_load(32'h203, 4'b0001, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80, "lb");
    data_load(32'h203, 4'b0001, 1'b0, 32'h80FF_0000, 32'h0000_0080, "lbu");
    data_load(32'h102, 4'b0011, 1'b1, 32'h9234_5678, 32'hFFFF_9234, "lh");
    data_load(32'h300, 4'b1111, 1'b1, 32'h8765_4321, 32'h8765_4321, "lw");

    // Halfword store at 0x102.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h102; d_byte_mask = 4'b0011;
    d_wdata = 32'h0000_ABCD; #1;
    check("sh_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0; mem_rdata = 32'h1234_5678; mem_ready = 1'b1; #1;
    check("sh_mem_en", mem_en, 1);
    check("sh_mem_we", mem_we, 4'b1100);
    check("sh_mem_wdata", mem_wdata, 32'hABCD_0000);
    check("sh_mem_addr", mem_addr, 32'h100);
    tick();
    mem_ready = 1'b0; d_we = 1'b0; #1;
    check("sh_rvalid", d_rvalid, 1);
    check("sh_rdata", d_rdata, 0);

    // Misaligned word load: straight to an error response, no memory access.
    tick();
    d_req = 1'b1; d_addr = 32'h101; d_byte_mask = 4'b1111; #1;
    check("mis_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0; #1;
    check("mis_rvalid", d_rvalid, 1);
    check("mis_err", d_err, 1);
    check("mis_rdata", d_rdata, 0);
    check("mis_mem_en", mem_en, 0);
    tick(); #1;
    check("mis_after", {d_rvalid, d_err, mem_en}, 0);

    // Conflicts from reset alternate data, fetch, data, fetch.
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80;
    d_byte_mask = 4'b1111; d_we = 1'b0; mem_rdata = 32'h5555_AAAA; #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("arb%0d_d_gnt", g), d_gnt, (g % 2 == 0) ? 1 : 0);
      check($sformatf("arb%0d_if_gnt", g), if_gnt, (g % 2 == 0) ? 0 : 1);
      tick();
      mem_ready = 1'b1; #1;
      check($sformatf("arb%0d_addr", g), mem_addr, (g % 2 == 0) ? 32'h80 : 32'h40);
      tick();
      mem_ready = 1'b0; #1;
      check($sformatf("arb%0d_rv", g), {if_rvalid, d_rvalid}, (g % 2 == 0) ? 2'b01 : 2'b10);
      tick(); #1;
    end
    if_req = 1'b0; d_req = 1'b0;

    // Reset asserted mid-BUSY drops the access with no late response.
    tick();
    if_req = 1'b1; if_addr = 32'h200; #1;
    check("rb_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0; #1;
    check("rb_en", mem_en, 1);
    rst_n = 1'b0; #1;
    check("rb_en_drop", mem_en, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1; #1;
      check($sformatf("rb_quiet%0d", c), {if_rvalid, d_rvalid, mem_en}, 0);
      tick();
    end
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h104; #1;
    check("rb2_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0; mem_rdata = 32'hCAFE_F00D; mem_ready = 1'b1; #1;
    check("rb2_addr", mem_addr, 32'h104);
    tick();
    mem_ready = 1'b0; #1;
    check("rb2_rvalid", if_rvalid, 1);
    check("rb2_rdata", if_rdata, 32'hCAFE_F00D);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so a broken design cannot hang the run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
